// File: rtl/matmul_controller_pkg.sv
// Shared coprocessor definitions: register file access codes and the
// matmul sequencer state encoding.
package coproc_pkg;

    typedef enum logic [1:0] {
        CELL = 2'b00,
        ROW  = 2'b01,
        COL  = 2'b10
    } rf_type_e;

    typedef enum logic [1:0] {
        MAT_A = 2'b00,
        MAT_B = 2'b01,
        MAT_C = 2'b10
    } mat_sel_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ_A = 3'd1,
        READ_B = 3'd2,
        CAPT_B = 3'd3,
        MAC    = 3'd4,
        WRITE  = 3'd5,
        DONE   = 3'd6
    } state_e;

    // Index counters need at least one bit even for a 1x1 matrix.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_controller_if.sv
// Command and register file port bundle between the decoder, the matmul
// sequencer and the three-matrix register file.
interface matmul_controller_if #(
    parameter int size          = 4,
    parameter int address_width = 4,
    parameter int cell_width    = 32,
    parameter int width         = cell_width * size
);
    logic                     in_start;
    logic                     out_busy;
    logic                     out_done;
    logic [address_width-1:0] out_rf_address;
    logic [1:0]               out_rf_type;
    logic [1:0]               out_rf_select;
    logic                     out_rf_read_en;
    logic                     out_rf_write_en;
    logic [width-1:0]         out_rf_data;
    logic [width-1:0]         in_rf_data;

    modport master (
        input  in_start, in_rf_data,
        output out_busy, out_done, out_rf_address, out_rf_type,
               out_rf_select, out_rf_read_en, out_rf_write_en, out_rf_data
    );

    modport slave (
        output in_start, in_rf_data,
        input  out_busy, out_done, out_rf_address, out_rf_type,
               out_rf_select, out_rf_read_en, out_rf_write_en, out_rf_data
    );
endinterface

// File: rtl/dot_product_mac.sv
// Single multiply-accumulate unit; product and sum both wrap modulo
// 2^cell_width, so signed operands yield the same low bits.
module dot_product_mac #(
    parameter int cell_width = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [cell_width-1:0] a,
    input  logic [cell_width-1:0] b,
    output logic [cell_width-1:0] acc
);
    logic [cell_width-1:0] acc_q, acc_d, prod;

    always_comb begin
        prod  = a * b;
        acc_d = acc_q;
        if (clear)       acc_d = '0;
        else if (enable) acc_d = acc_q + prod;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    assign acc = acc_q;
endmodule

// File: rtl/matmul_controller.sv
// C = A x B sequencer: per C cell it fetches row i of A and column j of B,
// runs size MAC cycles and writes the accumulator back as cell (i, j).
module matmul_controller
    import coproc_pkg::*;
#(
    parameter int size          = 4,
    parameter int address_width = 4,
    parameter int cell_width    = 32,
    parameter int width         = cell_width * size
) (
    input  logic                in_clk,
    input  logic                in_reset,
    matmul_controller_if.master bus
);
    localparam int unsigned IW = idx_bits(size);
    localparam logic [IW-1:0] LAST = IW'(size - 1);
    localparam logic [IW-1:0] ONE  = IW'(1);

    state_e state_q, state_d;
    logic [IW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [size-1:0][cell_width-1:0] row_q, row_d, col_q, col_d;
    logic [cell_width-1:0] acc;
    logic [address_width-1:0] row_base;
    logic last_k, last_cell;

    assign last_k    = (k_q == LAST);
    assign last_cell = (i_q == LAST) && (j_q == LAST);
    assign row_base  = address_width'(i_q) * address_width'(size);

    // State register
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_start) state_d = READ_A;
            READ_A:  state_d = READ_B;
            READ_B:  state_d = CAPT_B;
            CAPT_B:  state_d = MAC;
            MAC:     if (last_k) state_d = WRITE;
            WRITE:   state_d = last_cell ? DONE : READ_A;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Register file read data lands one cycle after the strobe, so the row
    // is captured in READ_B and the column in CAPT_B.
    always_comb begin
        i_d   = i_q;
        j_d   = j_q;
        k_d   = k_q;
        row_d = row_q;
        col_d = col_q;
        unique case (state_q)
            IDLE: if (bus.in_start) begin
                i_d = '0;
                j_d = '0;
            end
            READ_B: row_d = bus.in_rf_data;
            CAPT_B: begin
                col_d = bus.in_rf_data;
                k_d   = '0;
            end
            MAC: k_d = k_q + ONE;
            WRITE: begin
                if (j_q != LAST) begin
                    j_d = j_q + ONE;
                end else begin
                    j_d = '0;
                    if (i_q != LAST) i_d = i_q + ONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            row_q <= '0;
            col_q <= '0;
        end else begin
            i_q   <= i_d;
            j_q   <= j_d;
            k_q   <= k_d;
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    dot_product_mac #(.cell_width(cell_width)) u_mac (
        .clk    (in_clk),
        .rst_n  (in_reset),
        .clear  (state_q == CAPT_B),
        .enable (state_q == MAC),
        .a      (row_q[k_q]),
        .b      (col_q[k_q]),
        .acc    (acc)
    );

    // Outputs decode straight from state, so an async reset zeroes the bus
    // in the same cycle it asserts.
    always_comb begin
        bus.out_busy        = 1'b0;
        bus.out_done        = 1'b0;
        bus.out_rf_address  = '0;
        bus.out_rf_type     = 2'b00;
        bus.out_rf_select   = 2'b00;
        bus.out_rf_read_en  = 1'b0;
        bus.out_rf_write_en = 1'b0;
        bus.out_rf_data     = '0;
        unique case (state_q)
            READ_A: begin
                bus.out_busy       = 1'b1;
                bus.out_rf_read_en = 1'b1;
                bus.out_rf_type    = ROW;
                bus.out_rf_select  = MAT_A;
                bus.out_rf_address = row_base;
            end
            READ_B: begin
                bus.out_busy       = 1'b1;
                bus.out_rf_read_en = 1'b1;
                bus.out_rf_type    = COL;
                bus.out_rf_select  = MAT_B;
                bus.out_rf_address = address_width'(j_q);
            end
            CAPT_B, MAC: bus.out_busy = 1'b1;
            WRITE: begin
                bus.out_busy        = 1'b1;
                bus.out_rf_write_en = 1'b1;
                bus.out_rf_type     = CELL;
                bus.out_rf_select   = MAT_C;
                bus.out_rf_address  = row_base + address_width'(j_q);
                bus.out_rf_data     = width'(acc);
            end
            DONE:    bus.out_done = 1'b1;
            default: ;
        endcase
    end

    a_strobe_excl: assert property (@(posedge in_clk) disable iff (!in_reset)
        !(bus.out_rf_read_en && bus.out_rf_write_en));

endmodule

// File: tb/tb_matmul_controller.sv
// Self-checking bench: behavioural register file plus a plain-arithmetic
// matrix product reference.
module tb_matmul_controller;
    localparam int SZ = 2, AW = 4, CW = 32, W = CW * SZ, N = SZ * SZ;
    localparam int DONE_CYC = N * (SZ + 4) + 1;

    logic in_clk = 1'b0;
    logic in_reset = 1'b0;
    int checks = 0, errors = 0;

    logic [CW-1:0] ma [N];
    logic [CW-1:0] mb [N];
    logic [CW-1:0] mc [N];
    logic [CW-1:0] exp_c [N];
    int wr_addr [$];

    matmul_controller_if #(.size(SZ), .address_width(AW), .cell_width(CW)) bus ();

    matmul_controller #(.size(SZ), .address_width(AW), .cell_width(CW)) dut (
        .in_clk   (in_clk),
        .in_reset (in_reset),
        .bus      (bus)
    );

    always #5 in_clk = ~in_clk;

    // Row r of A / column c of B, element k in bits [k*CW +: CW].
    function automatic logic [W-1:0] rf_read(input logic [1:0] sel, input int addr);
        logic [W-1:0] v = '0;
        for (int k = 0; k < SZ; k++) begin
            if (sel == 2'b00) v[k*CW +: CW] = ma[(addr / SZ) * SZ + k];
            else              v[k*CW +: CW] = mb[k * SZ + (addr % SZ)];
        end
        return v;
    endfunction

    always @(posedge in_clk) begin
        if (bus.out_rf_read_en) bus.in_rf_data <= rf_read(bus.out_rf_select, int'(bus.out_rf_address));
        else                    bus.in_rf_data <= {$urandom, $urandom};
    end

    // Bus monitor and register file write port.
    always @(negedge in_clk) begin
        checks++;
        if (bus.out_rf_read_en && bus.out_rf_write_en) begin
            errors++;
            $display("FAIL strobe_overlap: read_en=1 write_en=1, required not both");
        end
        if (!bus.out_rf_read_en && !bus.out_rf_write_en) begin
            checks++;
            if ({bus.out_rf_address, bus.out_rf_type, bus.out_rf_select, bus.out_rf_data} !== '0) begin
                errors++;
                $display("FAIL bus_idle_zero: addr=%0h type=%0h sel=%0h data=%0h, required all 0",
                         bus.out_rf_address, bus.out_rf_type, bus.out_rf_select, bus.out_rf_data);
            end
        end
        if (bus.out_rf_read_en) begin
            checks++;
            if (!((bus.out_rf_select == 2'b00 && bus.out_rf_type == 2'b01 && int'(bus.out_rf_address) % SZ == 0) ||
                  (bus.out_rf_select == 2'b01 && bus.out_rf_type == 2'b10 && int'(bus.out_rf_address) < SZ))) begin
                errors++;
                $display("FAIL read_fields: sel=%0h type=%0h addr=%0h, required A-row or B-col",
                         bus.out_rf_select, bus.out_rf_type, bus.out_rf_address);
            end
        end
        if (bus.out_rf_write_en) begin
            checks++;
            if (bus.out_rf_type !== 2'b00 || bus.out_rf_select !== 2'b10 || bus.out_rf_data[W-1:CW] !== '0) begin
                errors++;
                $display("FAIL write_fields: type=%0h sel=%0h upper=%0h, required 0/2/0",
                         bus.out_rf_type, bus.out_rf_select, bus.out_rf_data[W-1:CW]);
            end
            mc[int'(bus.out_rf_address) % N] = bus.out_rf_data[CW-1:0];
            wr_addr.push_back(int'(bus.out_rf_address));
        end
    end

    function automatic void model_c();
        for (int i = 0; i < SZ; i++)
            for (int j = 0; j < SZ; j++) begin
                logic [CW-1:0] s = '0;
                for (int k = 0; k < SZ; k++) s = s + ma[i*SZ+k] * mb[k*SZ+j];
                exp_c[i*SZ+j] = s;
            end
    endfunction

    task automatic start_pulse();
        @(negedge in_clk); bus.in_start = 1'b1;
        @(posedge in_clk); #1 bus.in_start = 1'b0;
    endtask

    // Full run from a start pulse: busy window, done cycle, results, write order.
    task automatic run_and_check(input string name);
        int done_cyc = -1;
        model_c();
        for (int c = 0; c < N; c++) mc[c] = 32'hA5A5_5A5A;
        wr_addr.delete();
        start_pulse();
        for (int cyc = 1; cyc <= DONE_CYC + 10; cyc++) begin
            checks++;
            if (bus.out_busy !== (cyc < DONE_CYC)) begin
                errors++;
                $display("FAIL %s busy cyc%0d: got %b required %b", name, cyc, bus.out_busy, cyc < DONE_CYC);
            end
            if (bus.out_done === 1'b1) begin done_cyc = cyc; break; end
            @(posedge in_clk); #1;
        end
        checks++;
        if (done_cyc != DONE_CYC) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d required %0d", name, done_cyc, DONE_CYC);
        end
        @(posedge in_clk); #1;
        checks++;
        if (bus.out_done !== 1'b0 || bus.out_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_one_cycle: done=%b busy=%b required 0/0", name, bus.out_done, bus.out_busy);
        end
        for (int c = 0; c < N; c++) begin
            checks++;
            if (mc[c] !== exp_c[c]) begin
                errors++;
                $display("FAIL %s C[%0d]: got %0h required %0h", name, c, mc[c], exp_c[c]);
            end
        end
        checks++;
        if (wr_addr.size() != N) begin
            errors++;
            $display("FAIL %s write_count: got %0d required %0d", name, wr_addr.size(), N);
        end else begin
            for (int c = 0; c < N; c++) begin
                checks++;
                if (wr_addr[c] != c) begin
                    errors++;
                    $display("FAIL %s write_order[%0d]: got %0d required %0d", name, c, wr_addr[c], c);
                end
            end
        end
    endtask

    task automatic set_directed();
        ma = '{32'd1, 32'd2, 32'd3, 32'd4};
        mb = '{32'd5, 32'd6, 32'd7, 32'd8};
    endtask

    task automatic test_reset();
        bus.in_start = 1'b0;
        in_reset = 1'b0;
        repeat (3) @(posedge in_clk);
        #1;
        checks++;
        if ({bus.out_busy, bus.out_done, bus.out_rf_read_en, bus.out_rf_write_en} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/rd/wr=%b required 0000",
                     {bus.out_busy, bus.out_done, bus.out_rf_read_en, bus.out_rf_write_en});
        end
        checks++;
        if (bus.out_rf_address !== '0 || bus.out_rf_data !== '0) begin
            errors++;
            $display("FAIL reset_bus: addr=%0h data=%0h required 0", bus.out_rf_address, bus.out_rf_data);
        end
        @(negedge in_clk); in_reset = 1'b1;
    endtask

    task automatic test_directed();
        set_directed();
        run_and_check("directed");
        checks++;
        if (mc[0] !== 32'd19 || mc[1] !== 32'd22 || mc[2] !== 32'd43 || mc[3] !== 32'd50) begin
            errors++;
            $display("FAIL directed_const: got %0d %0d %0d %0d required 19 22 43 50", mc[0], mc[1], mc[2], mc[3]);
        end
    endtask

    task automatic test_identity();
        ma = '{32'd1, 32'd0, 32'd0, 32'd1};
        mb = '{32'd9, 32'd8, 32'd7, 32'd6};
        run_and_check("identity");
        for (int c = 0; c < N; c++) begin
            checks++;
            if (mc[c] !== mb[c]) begin
                errors++;
                $display("FAIL identity_eq_b[%0d]: got %0d required %0d", c, mc[c], mb[c]);
            end
        end
    endtask

    task automatic test_overflow();
        for (int c = 0; c < N; c++) begin ma[c] = 32'h0001_0000; mb[c] = 32'h0001_0000; end
        run_and_check("overflow");
        for (int c = 0; c < N; c++) begin
            checks++;
            if (mc[c] !== 32'd0) begin
                errors++;
                $display("FAIL overflow_wrap[%0d]: got %0h required 0", c, mc[c]);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < N; c++) begin
                ma[c] = (r < 3) ? 32'($urandom_range(0, 1000)) : $urandom;
                mb[c] = (r < 3) ? 32'($urandom_range(0, 1000)) : $urandom;
            end
            run_and_check($sformatf("random%0d", r));
        end
    endtask

    // Start held high: done once, IDLE one cycle, then a fresh run.
    task automatic test_start_held();
        int done_cyc = -1;
        set_directed();
        wr_addr.delete();
        @(negedge in_clk); bus.in_start = 1'b1;
        @(posedge in_clk); #1;
        for (int cyc = 1; cyc <= DONE_CYC + 2; cyc++) begin
            checks++;
            if (bus.out_busy !== (cyc < DONE_CYC || cyc == DONE_CYC + 2) || bus.out_done !== (cyc == DONE_CYC)) begin
                errors++;
                $display("FAIL start_held cyc%0d: busy=%b done=%b required %b/%b", cyc, bus.out_busy, bus.out_done,
                         (cyc < DONE_CYC || cyc == DONE_CYC + 2), cyc == DONE_CYC);
            end
            if (cyc == DONE_CYC) wr_addr.delete();
            if (cyc < DONE_CYC + 2) begin @(posedge in_clk); #1; end
        end
        bus.in_start = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus.out_done === 1'b1) begin done_cyc = cyc; break; end
            @(posedge in_clk); #1;
        end
        checks++;
        if (done_cyc < 0 || wr_addr.size() != N) begin
            errors++;
            $display("FAIL start_held_second_run: done_at=%0d writes=%0d required done and %0d writes",
                     done_cyc, wr_addr.size(), N);
        end
        @(posedge in_clk); #1;
    endtask

    // Reset asserted during MAC of cell (0,1): cycle 10 of the run.
    task automatic test_reset_mid();
        set_directed();
        for (int c = 0; c < N; c++) mc[c] = 32'hA5A5_5A5A;
        wr_addr.delete();
        start_pulse();
        repeat (9) @(posedge in_clk);
        #2 in_reset = 1'b0;
        #1;
        checks++;
        if ({bus.out_busy, bus.out_done, bus.out_rf_read_en, bus.out_rf_write_en} !== 4'b0 ||
            bus.out_rf_address !== '0 || bus.out_rf_data !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b rd=%b wr=%b required all 0",
                     bus.out_busy, bus.out_done, bus.out_rf_read_en, bus.out_rf_write_en);
        end
        repeat (2) @(posedge in_clk);
        @(negedge in_clk); in_reset = 1'b1;
        repeat (30) @(posedge in_clk);
        #1;
        checks++;
        if (mc[0] !== 32'd19 || mc[1] !== 32'hA5A5_5A5A || wr_addr.size() != 1) begin
            errors++;
            $display("FAIL reset_mid_cells: C00=%0d C01=%0h writes=%0d required 19 a5a55a5a 1",
                     mc[0], mc[1], wr_addr.size());
        end
        checks++;
        if (bus.out_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: busy=%b required 0", bus.out_busy);
        end
        run_and_check("after_reset");
    endtask

    initial begin
        bus.in_start = 1'b0;
        test_reset();
        test_directed();
        test_identity();
        test_overflow();
        test_random();
        test_start_held();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required finish before 200000");
        $fatal(1);
    end
endmodule
